lookup3_mix_stage: RTL
======================

Name: lookup3_mix_stage

Overview:
Upstream feeder for the lookup3 final-mix stage. Accepts a key byte stream with its length and initval, then packs bytes little-endian into 12-byte blocks (k0,k1,k2). It runs the lookup3 mix() on every block except the last, and hands the last 0..12-byte tail with the a/b/c state to the final stage via a valid/ready handshake.

Parameters:
MAX_LEN_W, 32, width of key length and remaining-byte counter.
INIT_CONST, 32'hDEADBEEF, lookup3 seed constant.

Ports:
clk  in  1  clock, all state on rising edge.
res  in  1  reset, asynchronous, active-low.
start_valid  in  1  new key descriptor present.
start_ready  out  1  stage idle, descriptor accepted when both high.
start_len  in  MAX_LEN_W  key length in bytes.
start_initval  in  32  hash initval.
in_valid  in  1  key byte present.
in_ready  out  1  byte accepted when both high.
in_data  in  8  key byte, in key order.
out_valid  out  1  tail block and state valid.
out_ready  in  1  downstream final stage accepts.
out_a, out_b, out_c  out  32 each  state after all non-final mixes.
out_k0, out_k1, out_k2  out  32 each  tail words, little-endian, unused bytes zero.
out_len  out  4  tail byte count, 0..12.

Behaviour:
- States: IDLE, LOAD, MIX, OUT.
- Reset while res low: state IDLE; a, b, c, k0-k2, rem, idx and out_len all 0; out_valid 0; in_ready 0; start_ready 1. Reset mid-operation discards the key; no partial output.
- start_ready = (state==IDLE); in_ready = (state==LOAD); out_valid = (state==OUT). Outputs are driven directly from the state and data registers.
- IDLE, start accepted: a=b=c=INIT_CONST+start_len+start_initval, all modulo 2^32. Also rem=start_len, idx=0, k0-k2=0. If start_len==0, go to OUT with out_len=0; otherwise go to LOAD.
- in_valid in IDLE/MIX/OUT: byte not consumed, no effect.
- LOAD, byte accepted: write byte into word idx/4 at bits 8*(idx%4)+7:8*(idx%4). Then idx++ and rem--.
  - If rem becomes 0: go to OUT, out_len=idx (new value, 1..12).
  - Else if idx reaches 12: a+=k0, b+=k1, c+=k2, clear k, idx=0, go to MIX.
  - A key of exactly 12 bytes therefore performs no mix.
- MIX: six cycles, one line each, rot(x,n)=(x<<n)|(x>>(32-n)). Then return to LOAD.
  - m0: a=(a-c)^rot(c,4); c=c+b
  - m1: b=(b-a)^rot(a,6); a=a+c
  - m2: c=(c-b)^rot(b,8); b=b+a
  - m3: a=(a-c)^rot(c,16); c=c+b
  - m4: b=(b-a)^rot(a,19); a=a+c
  - m5: c=(c-b)^rot(b,4); b=b+a
- In each line, the second assignment uses the value just updated.
- OUT: all out_* held stable while out_ready is low. On handshake go to IDLE; start_ready rises on the next cycle, so the minimum gap between keys is 1 cycle.
- Throughput without the optional feature: 12 byte cycles + 6 mix cycles per non-final block.
- All arithmetic is 32-bit wrap-around; no overflow detection.

Optional Feature:
LOOKUP3_MIX_ONECYCLE_EN:
- Defined: MIX is a single cycle evaluating m0-m5 combinationally in sequence; bit-identical results.
- Undefined: six-cycle MIX as above.

Test Plan:
- Empty key: start_len=0, initval=0 -> OUT next cycle, out_a=out_b=out_c=0xDEADBEEF, out_len=0, k all 0.
- "abcdefghijkl" (len 12, initval 0) -> no MIX, a=b=c=0xDEADBEFB, k0=0x64636261, k1=0x68676665, k2=0x6C6B6A69, out_len=12.
- "hello" (len 5) -> k0=0x6C6C6568, k1=0x0000006F, k2=0, out_len=5, a=b=c=0xDEADBEF4.
- "abcdefghijklm" (len 13) -> exactly one MIX (6 cycles, or 1 with the macro), out_k0=0x0000006D, out_len=1, a/b/c equal to the C hashlittle state before final; repeat with random lengths 1..100 against the C model.
- Backpressure and flow: out_ready low 10 cycles -> outputs constant, start_ready 0; random in_valid gaps -> identical results.
- Async reset asserted mid-LOAD of a 30-byte key -> out_valid 0 immediately, start_ready 1; next key hashes correctly.

Source files
------------

// File: rtl/lookup3_mix_stage_if.sv
// lookup3 feeder bus: descriptor, byte stream and tail/state result.
// master drives descriptors and bytes, slave is the feeder stage.
interface lookup3_mix_stage_if #(
   parameter int MAX_LEN_W = 32
);
   logic                 start_valid;
   logic                 start_ready;
   logic [MAX_LEN_W-1:0] start_len;
   logic [31:0]          start_initval;

   logic                 in_valid;
   logic                 in_ready;
   logic [7:0]           in_data;

   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_a;
   logic [31:0]          out_b;
   logic [31:0]          out_c;
   logic [31:0]          out_k0;
   logic [31:0]          out_k1;
   logic [31:0]          out_k2;
   logic [3:0]           out_len;

   modport master (
      output start_valid,
      output start_len,
      output start_initval,
      input  start_ready,
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      output out_ready,
      input  out_a,
      input  out_b,
      input  out_c,
      input  out_k0,
      input  out_k1,
      input  out_k2,
      input  out_len
   );

   modport slave (
      input  start_valid,
      input  start_len,
      input  start_initval,
      output start_ready,
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      input  out_ready,
      output out_a,
      output out_b,
      output out_c,
      output out_k0,
      output out_k1,
      output out_k2,
      output out_len
   );
endinterface

// File: rtl/lookup3_mix_stage.sv
// lookup3 feeder: packs key bytes into 12-byte blocks, mixes all but the last.
// LOOKUP3_MIX_ONECYCLE_EN collapses the six-cycle mix into one cycle.
module lookup3_mix_stage #(
   parameter int          MAX_LEN_W  = 32,
   parameter logic [31:0] INIT_CONST = 32'hDEADBEEF
) (
   input logic                clk,
   input logic                res,
   lookup3_mix_stage_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_MIX  = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } abc_t;

   logic [1:0]           state;
   logic [31:0]          a;
   logic [31:0]          b;
   logic [31:0]          c;
   logic [31:0]          k0;
   logic [31:0]          k1;
   logic [31:0]          k2;
   logic [MAX_LEN_W-1:0] rem;
   logic [3:0]           idx;
   logic [3:0]           out_len;

   function automatic logic [31:0] rot(
      input logic [31:0] x,
      input int          n
   );
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic abc_t mix_step(
      input logic [2:0] s,
      input abc_t       v
   );
      abc_t r;
      r = v;
      unique case (s)
         3'd0: begin
            r.a = (v.a - v.c) ^ rot(v.c, 4);
            r.c = v.c + v.b;
         end
         3'd1: begin
            r.b = (v.b - v.a) ^ rot(v.a, 6);
            r.a = v.a + v.c;
         end
         3'd2: begin
            r.c = (v.c - v.b) ^ rot(v.b, 8);
            r.b = v.b + v.a;
         end
         3'd3: begin
            r.a = (v.a - v.c) ^ rot(v.c, 16);
            r.c = v.c + v.b;
         end
         3'd4: begin
            r.b = (v.b - v.a) ^ rot(v.a, 19);
            r.a = v.a + v.c;
         end
         3'd5: begin
            r.c = (v.c - v.b) ^ rot(v.b, 4);
            r.b = v.b + v.a;
         end
         default: r = v;
      endcase
      return r;
   endfunction

   abc_t cur;
   abc_t mixed;

   assign cur = {a, b, c};

`ifdef LOOKUP3_MIX_ONECYCLE_EN
   always_comb begin
      abc_t t;
      t = cur;
      for (int i = 0; i < 6; i++) begin
         t = mix_step(3'(i), t);
      end
      mixed = t;
   end
`else
   logic [2:0] step;

   assign mixed = mix_step(step, cur);
`endif

   // Tail bytes are zero, so OR-ing the shifted lane is a byte write.
   logic [31:0]          lane;
   logic [31:0]          k0_n;
   logic [31:0]          k1_n;
   logic [31:0]          k2_n;
   logic [3:0]           idx_n;
   logic [MAX_LEN_W-1:0] rem_n;
   logic [31:0]          seed;

   assign lane  = 32'(bus.in_data) << {idx[1:0], 3'b000};
   assign k0_n  = k0 | ((idx[3:2] == 2'd0) ? lane : 32'd0);
   assign k1_n  = k1 | ((idx[3:2] == 2'd1) ? lane : 32'd0);
   assign k2_n  = k2 | ((idx[3:2] == 2'd2) ? lane : 32'd0);
   assign idx_n = idx + 4'd1;
   assign rem_n = rem - 1'b1;
   assign seed  = INIT_CONST
                + 32'(bus.start_len)
                + bus.start_initval;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state   <= S_IDLE;
         a       <= '0;
         b       <= '0;
         c       <= '0;
         k0      <= '0;
         k1      <= '0;
         k2      <= '0;
         rem     <= '0;
         idx     <= '0;
         out_len <= '0;
`ifndef LOOKUP3_MIX_ONECYCLE_EN
         step    <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start_valid) begin
                  a   <= seed;
                  b   <= seed;
                  c   <= seed;
                  rem <= bus.start_len;
                  idx <= '0;
                  k0  <= '0;
                  k1  <= '0;
                  k2  <= '0;
                  if (bus.start_len == '0) begin
                     out_len <= '0;
                     state   <= S_OUT;
                  end else begin
                     state   <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (bus.in_valid) begin
                  k0  <= k0_n;
                  k1  <= k1_n;
                  k2  <= k2_n;
                  idx <= idx_n;
                  rem <= rem_n;
                  if (rem_n == '0) begin
                     out_len <= idx_n;
                     state   <= S_OUT;
                  end else if (idx_n == 4'd12) begin
                     a     <= a + k0_n;
                     b     <= b + k1_n;
                     c     <= c + k2_n;
                     k0    <= '0;
                     k1    <= '0;
                     k2    <= '0;
                     idx   <= '0;
                     state <= S_MIX;
                  end
               end
            end
            S_MIX: begin
               a <= mixed.a;
               b <= mixed.b;
               c <= mixed.c;
`ifdef LOOKUP3_MIX_ONECYCLE_EN
               state <= S_LOAD;
`else
               if (step == 3'd5) begin
                  step  <= '0;
                  state <= S_LOAD;
               end else begin
                  step  <= step + 3'd1;
               end
`endif
            end
            S_OUT: begin
               if (bus.out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.start_ready = (state == S_IDLE);
   assign bus.in_ready    = (state == S_LOAD);
   assign bus.out_valid   = (state == S_OUT);
   assign bus.out_a       = a;
   assign bus.out_b       = b;
   assign bus.out_c       = c;
   assign bus.out_k0      = k0;
   assign bus.out_k1      = k1;
   assign bus.out_k2      = k2;
   assign bus.out_len     = out_len;

endmodule
